// File: rtl/memory_writeback_pkg.sv
// Shared definitions for the memory-access / writeback stage.
//   mw_state_e     : stage FSM states
//   OP_LW, OP_SW   : primary opcodes shared with the decode stage
//   REG_ADDR_W,
//   DATA_W, WB_W   : widths of the writeback bundle fields
//   mem_op_t       : EX/MEM fields latched while a memory access is outstanding
package memory_writeback_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mw_state_e;

  localparam logic [5:0] OP_LW = 6'd35;
  localparam logic [5:0] OP_SW = 6'd43;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  // MemtoReg + RegWrite + RD + MDR + ALUout
  localparam int WB_W       = 2 + REG_ADDR_W + 2 * DATA_W;

  typedef struct packed {
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     alu_out;
  } mem_op_t;

endpackage

// File: rtl/mem_watchdog.sv
// Cycle counter bounding how long an access may wait for dm_ready.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : force the count to zero (held while no access is pending)
//   enable     : advance the count by one
//   expire     : count has reached TIMEOUT-1 (combinational)
module mem_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CNT_W'(1);
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/memory_writeback.sv
// Memory-access stage and producer of the registered MW_* writeback bus.
//   clk, rst_n            : clock, synchronous active-low reset
//   xm_*                  : EX/MEM pipeline register contents
//   dm_req/we/addr/wdata  : registered data-memory request
//   dm_rdata, dm_ready    : data-memory response
//   stall                 : upstream must hold xm_* this cycle
//   MW_*, MDR             : writeback bundle to the register file
//   align_err             : one-cycle pulse, misaligned lw/sw dropped
//   bus_err               : sticky, a watchdog abort has occurred
module memory_writeback
  import memory_writeback_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              xm_valid,
  input  logic              xm_MemtoReg,
  input  logic              xm_RegWrite,
  input  logic              xm_MemRead,
  input  logic              xm_MemWrite,
  input  logic [4:0]        xm_RD,
  input  logic [31:0]       xm_ALUout,
  input  logic [31:0]       xm_MD,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ready,
  output logic              stall,
  output logic              MW_MemtoReg,
  output logic              MW_RegWrite,
  output logic [4:0]        MW_RD,
  output logic [31:0]       MDR,
  output logic [31:0]       MW_ALUout,
  output logic              align_err,
  output logic              bus_err
);

  mw_state_e state, next_state;
  mem_op_t   op;
  logic      memop, misaligned, expire, wd_clear, wd_enable;

  assign memop      = xm_valid & (xm_MemRead | xm_MemWrite);
  assign misaligned = (xm_ALUout[1:0] != 2'b00);

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    unique case (state)
      IDLE: begin
        wd_clear = 1'b1;
        if (memop && !misaligned) begin
          stall      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        // dm_ready takes priority over an expiring watchdog.
        if (dm_ready || expire) begin
          next_state = IDLE;
        end else begin
          stall     = 1'b1;
          wd_enable = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      MW_MemtoReg <= 1'b0;
      MW_RegWrite <= 1'b0;
      MW_RD       <= '0;
      MDR         <= '0;
      MW_ALUout   <= '0;
      align_err   <= 1'b0;
      bus_err     <= 1'b0;
      op          <= '0;
    end else begin
      align_err   <= 1'b0;
      // Writeback is valid for a single cycle unless a branch below says so.
      MW_RegWrite <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xm_valid && !memop) begin
            MW_MemtoReg <= xm_MemtoReg;
            MW_RegWrite <= xm_RegWrite;
            MW_RD       <= xm_RD;
            MW_ALUout   <= xm_ALUout;
          end else if (memop && misaligned) begin
            align_err <= 1'b1;
          end else if (memop) begin
            dm_req   <= 1'b1;
            dm_we    <= xm_MemWrite;
            dm_addr  <= xm_ALUout[ADDR_W-1:0];
            dm_wdata <= xm_MD;
            op       <= '{mem_to_reg: xm_MemtoReg, reg_write: xm_RegWrite,
                          mem_read: xm_MemRead, mem_write: xm_MemWrite,
                          rd: xm_RD, alu_out: xm_ALUout};
          end
        end
        ACCESS: begin
          if (dm_ready) begin
            dm_req      <= 1'b0;
            MW_MemtoReg <= op.mem_to_reg;
            MW_RD       <= op.rd;
            MW_ALUout   <= op.alu_out;
            // A store never writes the register file.
            MW_RegWrite <= op.reg_write & ~op.mem_write;
            if (op.mem_read && !op.mem_write) MDR <= dm_rdata;
          end else if (expire) begin
            dm_req  <= 1'b0;
            bus_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
